// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Field-bundle input channel, encoded-word output channel and address-base
// control for instr_encoder.
//   input channel  : in_valid_i / in_ready_o plus opcode_i, funct3_i, funct7_i,
//                    rd_i, rs1_i, rs2_i, imm_i
//   address control: base_load_i, base_addr_i
//   output channel : out_valid_o / out_ready_i plus instr_o, illegal_o,
//                    addr_o, err_cnt_o
// master = program generator side, slave = encoder.
interface instr_encoder_if;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [4:0]  opcode_i;
   logic [2:0]  funct3_i;
   logic [6:0]  funct7_i;
   logic [4:0]  rd_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [31:0] imm_i;
   logic        base_load_i;
   logic [31:0] base_addr_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] instr_o;
   logic        illegal_o;
   logic [31:0] addr_o;
   logic [7:0]  err_cnt_o;

   modport master (
      output in_valid_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i,
             imm_i, base_load_i, base_addr_i, out_ready_i,
      input  in_ready_o, out_valid_o, instr_o, illegal_o, addr_o, err_cnt_o
   );

   modport slave (
      input  in_valid_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i,
             imm_i, base_load_i, base_addr_i, out_ready_i,
      output in_ready_o, out_valid_o, instr_o, illegal_o, addr_o, err_cnt_o
   );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder
// Streaming RV32I encoder: range-checks an instruction field bundle, packs the
// 32-bit machine word and tags it with a running byte address. One output
// register, latency 1, full throughput while the consumer is ready.
// Ports:
//   clk_i      clock, all state on the rising edge
//   rst_i      synchronous active-high reset
//   bus        instr_encoder_if.slave (input bundle, base load, output word)
// RESET_ADDR   address register value after reset
module instr_encoder #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input logic            clk_i,
   input logic            rst_i,
   instr_encoder_if.slave bus
);
   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [31:0]        imm;
   logic signed [31:0] imm_s;
   logic [4:0]         opc;
   logic [2:0]         f3;
   logic [6:0]         f7;

   logic [31:0] w_r, w_i, w_sh, w_s, w_b, w_u, w_j;
   logic [31:0] word;
   logic        ill;
   logic        imm12_bad;

   logic        valid_q;
   logic [31:0] instr_q;
   logic        ill_q;
   logic [31:0] out_addr_q;
   logic [31:0] addr_q;
   logic [7:0]  err_q;

   logic        in_ready;
   logic        accept;
   logic        out_hs;
   logic [31:0] addr_adv;
   logic [31:0] addr_next;

   assign imm   = bus.imm_i;
   assign imm_s = bus.imm_i;
   assign opc   = bus.opcode_i;
   assign f3    = bus.funct3_i;
   assign f7    = bus.funct7_i;

   assign w_r  = {f7, bus.rs2_i, bus.rs1_i, f3, bus.rd_i, opc, 2'b11};
   assign w_i  = {imm[11:0], bus.rs1_i, f3, bus.rd_i, opc, 2'b11};
   assign w_sh = {f7, imm[4:0], bus.rs1_i, f3, bus.rd_i, opc, 2'b11};
   assign w_s  = {imm[11:5], bus.rs2_i, bus.rs1_i, f3, imm[4:0], opc, 2'b11};
   assign w_b  = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, f3, imm[4:1],
                  imm[11], opc, 2'b11};
   assign w_u  = {imm[31:12], bus.rd_i, opc, 2'b11};
   assign w_j  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, opc, 2'b11};

   assign imm12_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);

   always_comb begin
      word = 32'h0;
      ill  = 1'b0;
      unique case (opc)
         OPC_OP: begin
            word = w_r;
            ill  = !((f7 == F7_ZERO) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_OP_IMM: begin
            if ((f3 == 3'b001) || (f3 == 3'b101)) begin
               word = w_sh;
               // shift amount travels in imm_i and must fit 5 bits unsigned
               ill  = (imm > 32'd31) ||
                      ((f3 == 3'b001) && (f7 != F7_ZERO)) ||
                      ((f3 == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT));
            end else begin
               word = w_i;
               ill  = imm12_bad;
            end
         end
         OPC_LOAD: begin
            word = w_i;
            ill  = imm12_bad || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_JALR: begin
            word = w_i;
            ill  = imm12_bad || (f3 != 3'b000);
         end
         OPC_MISC_MEM: begin
            word = w_i;
         end
         OPC_SYSTEM: begin
            word = w_i;
            ill  = imm > 32'd4095;
         end
         OPC_STORE: begin
            word = w_s;
            ill  = imm12_bad || (f3[2] == 1'b1) || (f3 == 3'b011);
         end
         OPC_BRANCH: begin
            word = w_b;
            ill  = (f3 == 3'b010) || (f3 == 3'b011) ||
                   (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
         end
         OPC_LUI, OPC_AUIPC: begin
            word = w_u;
            ill  = imm[11:0] != 12'h000;
         end
         OPC_JAL: begin
            word = w_j;
            ill  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
         end
         default: begin
            ill = 1'b1;
         end
      endcase
   end

   assign in_ready = !valid_q || bus.out_ready_i;
   assign accept   = bus.in_valid_i && in_ready;
   assign out_hs   = valid_q && bus.out_ready_i;

   // A new word captured alongside a handshake takes the post-advance address;
   // a same-cycle base load only lands in addr_q for later captures.
   assign addr_adv  = (out_hs && !ill_q) ? addr_q + 32'd4 : addr_q;
   assign addr_next = bus.base_load_i ? (bus.base_addr_i & 32'hFFFF_FFFC) : addr_adv;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         instr_q    <= 32'h0;
         ill_q      <= 1'b0;
         out_addr_q <= RESET_ADDR;
         addr_q     <= RESET_ADDR;
         err_q      <= 8'h00;
      end else begin
         addr_q <= addr_next;
         if (out_hs && ill_q && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
         end
         if (accept) begin
            valid_q    <= 1'b1;
            instr_q    <= ill ? 32'h0 : word;
            ill_q      <= ill;
            out_addr_q <= addr_adv;
         end else if (out_hs) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = valid_q;
   assign bus.instr_o     = instr_q;
   assign bus.illegal_o   = ill_q;
   assign bus.addr_o      = out_addr_q;
   assign bus.err_cnt_o   = err_q;
endmodule
